// File: rtl/prirv32_idu.sv
// prirv32_idu: instruction decode stage of the priRV32 core.
// Accepts a fetched RV32I/Zicsr/Zifencei instruction plus its PC over a
// valid/ready handshake. It decodes the instruction into a 47-bit one-hot
// vector, an immediate, the two operand values and rd. The result is held in
// one registered output stage with backpressure, flush and write-back bypass.
//
// Ports:
//   clk_in, rst_n                  clock, async active-low reset
//   in_valid/in_ready              upstream handshake for instr_in/instr_pc
//   flush                          drop held and incoming instruction
//   rf_raddr1/2, rf_rdata1/2       combinational regfile read port
//   wb_en, wb_rd, wb_data          write-back bypass source
//   out_valid/out_ready            downstream handshake for the decoded outputs
//   instrset_latched ... illegal_instr   registered decode results
module prirv32_idu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] instr_pc,
  input  logic        flush,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [46:0] instrset_latched,
  output logic [31:0] imm_decoded,
  output logic [31:0] rs1_decoded,
  output logic [31:0] rs2_decoded,
  output logic [4:0]  rd_decoded,
  output logic [31:0] pc_decoded,
  output logic        illegal_instr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111, OP_AUIPC  = 7'b0010111,
                         OP_JAL    = 7'b1101111, OP_JALR   = 7'b1100111,
                         OP_BRANCH = 7'b1100011, OP_LOAD   = 7'b0000011,
                         OP_STORE  = 7'b0100011, OP_IMM    = 7'b0010011,
                         OP_REG    = 7'b0110011, OP_MISC   = 7'b0001111,
                         OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [46:0] iset_d;
  logic [31:0] imm_d, rs1_d, rs2_d;
  logic [4:0]  rd_d;
  logic        illegal_d;
  logic        is_i, is_s, is_b, is_u, is_j, is_sh, is_csr, is_csri, no_rd;
  logic        capture;

  assign opcode    = instr_in[6:0];
  assign f3        = instr_in[14:12];
  assign f7        = instr_in[31:25];
  assign rf_raddr1 = instr_in[19:15];
  assign rf_raddr2 = instr_in[24:20];
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf,
                                          input logic en, input logic [4:0] rd,
                                          input logic [31:0] data);
    if (idx == 5'd0)           return '0;
    else if (en && rd == idx)  return data;
    else                       return rf;
  endfunction

  // One-hot decode; bit positions follow the execute unit's instruction-set map.
  always_comb begin
    iset_d = '0;
    unique case (opcode)
      OP_LUI:    iset_d[46] = 1'b1;
      OP_AUIPC:  iset_d[45] = 1'b1;
      OP_JAL:    iset_d[44] = 1'b1;
      OP_JALR:   iset_d[43] = (f3 == 3'b000);
      OP_BRANCH: case (f3)
                   3'b000: iset_d[42] = 1'b1;  3'b001: iset_d[41] = 1'b1;
                   3'b100: iset_d[40] = 1'b1;  3'b101: iset_d[39] = 1'b1;
                   3'b110: iset_d[38] = 1'b1;  3'b111: iset_d[37] = 1'b1;
                   default: ;
                 endcase
      OP_LOAD:   case (f3)
                   3'b000: iset_d[36] = 1'b1;  3'b001: iset_d[35] = 1'b1;
                   3'b010: iset_d[34] = 1'b1;  3'b100: iset_d[33] = 1'b1;
                   3'b101: iset_d[32] = 1'b1;
                   default: ;
                 endcase
      OP_STORE:  case (f3)
                   3'b000: iset_d[31] = 1'b1;  3'b001: iset_d[30] = 1'b1;
                   3'b010: iset_d[29] = 1'b1;
                   default: ;
                 endcase
      OP_IMM:    case (f3)
                   3'b000: iset_d[28] = 1'b1;  3'b010: iset_d[27] = 1'b1;
                   3'b011: iset_d[26] = 1'b1;  3'b100: iset_d[25] = 1'b1;
                   3'b110: iset_d[24] = 1'b1;  3'b111: iset_d[23] = 1'b1;
                   3'b001: iset_d[22] = (f7 == F7_BASE);
                   3'b101: begin
                     iset_d[21] = (f7 == F7_BASE);
                     iset_d[20] = (f7 == F7_ALT);
                   end
                   default: ;
                 endcase
      OP_REG:    if (f7 == F7_BASE) begin
                   case (f3)
                     3'b000: iset_d[19] = 1'b1;  3'b001: iset_d[17] = 1'b1;
                     3'b010: iset_d[16] = 1'b1;  3'b011: iset_d[15] = 1'b1;
                     3'b100: iset_d[14] = 1'b1;  3'b101: iset_d[13] = 1'b1;
                     3'b110: iset_d[11] = 1'b1;  3'b111: iset_d[10] = 1'b1;
                     default: ;
                   endcase
                 end else if (f7 == F7_ALT) begin
                   iset_d[18] = (f3 == 3'b000);
                   iset_d[12] = (f3 == 3'b101);
                 end
      OP_MISC:   begin
                   iset_d[9] = (f3 == 3'b000);
                   iset_d[8] = (f3 == 3'b001);
                 end
      OP_SYSTEM: if (instr_in == 32'h0000_0073)      iset_d[7] = 1'b1;
                 else if (instr_in == 32'h0010_0073) iset_d[6] = 1'b1;
                 else case (f3)
                   3'b001: iset_d[5] = 1'b1;  3'b010: iset_d[4] = 1'b1;
                   3'b011: iset_d[3] = 1'b1;  3'b101: iset_d[2] = 1'b1;
                   3'b110: iset_d[1] = 1'b1;  3'b111: iset_d[0] = 1'b1;
                   default: ;
                 endcase
      default: ;
    endcase
  end

  // Immediate format, operand and rd selection keyed off the decoded vector.
  always_comb begin
    illegal_d = ~|iset_d;
    is_i    = iset_d[43] | (|iset_d[36:32]) | (|iset_d[28:23]);
    is_s    = |iset_d[31:29];
    is_b    = |iset_d[42:37];
    is_u    = iset_d[46] | iset_d[45];
    is_j    = iset_d[44];
    is_sh   = |iset_d[22:20];
    is_csr  = |iset_d[5:0];
    is_csri = |iset_d[2:0];
    no_rd   = is_b | is_s | (|iset_d[9:6]) | illegal_d;

    imm_d = '0;
    if (is_i)        imm_d = {{20{instr_in[31]}}, instr_in[31:20]};
    else if (is_s)   imm_d = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    else if (is_b)   imm_d = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
    else if (is_u)   imm_d = {instr_in[31:12], 12'b0};
    else if (is_j)   imm_d = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
    else if (is_sh)  imm_d = {27'b0, instr_in[24:20]};
    else if (is_csr) imm_d = {20'b0, instr_in[31:20]};

    rs1_d = is_csri ? {27'b0, instr_in[19:15]}
                    : operand(rf_raddr1, rf_rdata1, wb_en, wb_rd, wb_data);
    rs2_d = operand(rf_raddr2, rf_rdata2, wb_en, wb_rd, wb_data);
    rd_d  = no_rd ? 5'd0 : instr_in[11:7];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      instrset_latched <= '0;
      imm_decoded      <= '0;
      rs1_decoded      <= '0;
      rs2_decoded      <= '0;
      rd_decoded       <= '0;
      pc_decoded       <= RESET_PC;
      illegal_instr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid        <= 1'b1;
      instrset_latched <= iset_d;
      imm_decoded      <= imm_d;
      rs1_decoded      <= rs1_d;
      rs2_decoded      <= rs2_d;
      rd_decoded       <= rd_d;
      pc_decoded       <= instr_pc;
      illegal_instr    <= illegal_d;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prirv32_idu.sv
// Directed-vector bench for prirv32_idu with hand-computed expectations.
module tb_prirv32_idu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, illegal_instr;
  logic [31:0] instr_in, instr_pc, rf_rdata1, rf_rdata2, wb_data;
  logic [31:0] imm_decoded, rs1_decoded, rs2_decoded, pc_decoded;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, rd_decoded;
  logic [46:0] instrset_latched;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  prirv32_idu #(.RESET_PC(RPC)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .instr_pc(instr_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .instrset_latched(instrset_latched), .imm_decoded(imm_decoded),
    .rs1_decoded(rs1_decoded), .rs2_decoded(rs2_decoded),
    .rd_decoded(rd_decoded), .pc_decoded(pc_decoded),
    .illegal_instr(illegal_instr)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bit1(input int unsigned b);
    logic [63:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Present one instruction and let one rising edge pass; returns at edge+1.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    instr_in = instr;
    instr_pc = pc;
    @(posedge clk_in);
    #1;
  endtask

  // Check the full registered decode of a captured instruction.
  task automatic expect_dec(input string tag, input logic [63:0] iset, input logic [31:0] imm,
                            input logic [4:0] rd, input logic ill);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".iset"},  64'(instrset_latched), iset);
    check({tag, ".imm"},   64'(imm_decoded), 64'(imm));
    check({tag, ".rd"},    64'(rd_decoded), 64'(rd));
    check({tag, ".ill"},   64'(illegal_instr), 64'(ill));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    instr_in = '0; instr_pc = '0; rf_rdata1 = '0; rf_rdata2 = '0; wb_rd = '0; wb_data = '0;
    #12;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.iset",  64'(instrset_latched), 64'd0);
    check("rst.imm",   64'(imm_decoded), 64'd0);
    check("rst.rs1",   64'(rs1_decoded), 64'd0);
    check("rst.rs2",   64'(rs2_decoded), 64'd0);
    check("rst.rd",    64'(rd_decoded), 64'd0);
    check("rst.pc",    64'(pc_decoded), 64'(RPC));
    check("rst.ill",   64'(illegal_instr), 64'd0);
    check("rst.inrdy", 64'(in_ready), 64'd1);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);

    // addi x1,x0,5 with a write-back to x0 that must not bypass
    rf_rdata1 = 32'h55; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    issue(32'h0050_0093, 32'h100);
    expect_dec("addi", bit1(28), 32'd5, 5'd1, 1'b0);
    check("addi.rs1", 64'(rs1_decoded), 64'd0);
    check("addi.pc",  64'(pc_decoded), 64'h100);

    wb_en = 1'b0;
    issue(32'h1234_5137, 32'h104);
    expect_dec("lui", bit1(46), 32'h1234_5000, 5'd2, 1'b0);

    // beq x1,x2,-4 with bypass on x2
    rf_rdata1 = 32'd7; rf_rdata2 = 32'd9; wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hAA;
    instr_in = 32'hFE20_8EE3;
    #1;
    check("beq.raddr1", 64'(rf_raddr1), 64'd1);
    check("beq.raddr2", 64'(rf_raddr2), 64'd2);
    issue(32'hFE20_8EE3, 32'h108);
    expect_dec("beq", bit1(42), 32'hFFFF_FFFC, 5'd0, 1'b0);
    check("beq.rs1", 64'(rs1_decoded), 64'd7);
    check("beq.rs2", 64'(rs2_decoded), 64'hAA);

    // backpressure: add x3,x1,x2 waits while out_ready=0
    wb_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h0020_81B3; instr_pc = 32'h10C;
    #1;
    check("bp.inrdy", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.iset",  64'(instrset_latched), bit1(42));
      check("bp.pc",    64'(pc_decoded), 64'h108);
    end
    out_ready = 1'b1;
    #1;
    check("bp.inrdy1", 64'(in_ready), 64'd1);
    @(posedge clk_in);
    #1;
    expect_dec("add", bit1(19), 32'd0, 5'd3, 1'b0);
    check("add.rs1", 64'(rs1_decoded), 64'd7);
    check("add.rs2", 64'(rs2_decoded), 64'd9);

    // flush beats a simultaneous capture (sub x5,x1,x2)
    flush = 1'b1;
    issue(32'h4020_82B3, 32'h110);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.iset",  64'(instrset_latched), bit1(19));
    check("flush.rd",    64'(rd_decoded), 64'd3);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk_in);
    #1;
    check("idle.valid", 64'(out_valid), 64'd0);

    issue(32'h4020_82B3, 32'h110);
    expect_dec("sub", bit1(18), 32'd0, 5'd5, 1'b0);

    // more formats
    issue(32'h4030_D313, 32'h114);
    expect_dec("srai", bit1(20), 32'd3, 5'd6, 1'b0);
    issue(32'h3052_D3F3, 32'h118);
    expect_dec("csrrwi", bit1(2), 32'h305, 5'd7, 1'b0);
    check("csrrwi.rs1", 64'(rs1_decoded), 64'd5);
    issue(32'h0080_00EF, 32'h11C);
    expect_dec("jal", bit1(44), 32'd8, 5'd1, 1'b0);
    issue(32'hFE20_AC23, 32'h120);
    expect_dec("sw", bit1(29), 32'hFFFF_FFF8, 5'd0, 1'b0);
    issue(32'h0000_0073, 32'h124);
    expect_dec("ecall", bit1(7), 32'd0, 5'd0, 1'b0);
    issue(32'h0010_0073, 32'h128);
    expect_dec("ebreak", bit1(6), 32'd0, 5'd0, 1'b0);
    issue(32'h0200_1033, 32'h12C);
    expect_dec("badf7", 64'd0, 32'd0, 5'd0, 1'b1);

    // all-ones word is illegal; then async reset mid-hold
    issue(32'hFFFF_FFFF, 32'h130);
    expect_dec("illegal", 64'd0, 32'd0, 5'd0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk_in);
    #2;
    check("hold.valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.ill",   64'(illegal_instr), 64'd0);
    check("arst.pc",    64'(pc_decoded), 64'(RPC));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/prirv32_idu.md
Name: prirv32_idu

Overview:
- Instruction decode stage of the priRV32 core; the producing end of the decoded-instruction interface consumed by the execute unit.
- Accepts a fetched 32-bit RV32I/Zicsr/Zifencei instruction and its PC over a valid/ready handshake.
- Decodes it into a 47-bit one-hot instruction-set vector, sign-extended immediate, source operand values and destination index.
- Holds the result in a single registered output stage with valid/ready backpressure, flush, and a write-back bypass.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on pc_decoded at reset.

Ports:
- clk_in  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instr_in/instr_pc valid.
- in_ready  output  1  stage can accept this cycle.
- instr_in  input  32  instruction word.
- instr_pc  input  32  PC of instr_in.
- flush  input  1  discard held/incoming instruction (branch redirect).
- rf_raddr1  output  5  regfile read address = instr_in[19:15] (combinational).
- rf_raddr2  output  5  regfile read address = instr_in[24:20] (combinational).
- rf_rdata1  input  32  regfile data for rf_raddr1, same cycle.
- rf_rdata2  input  32  regfile data for rf_raddr2, same cycle.
- wb_en  input  1  write-back this cycle.
- wb_rd  input  5  write-back register.
- wb_data  input  32  write-back value.
- out_valid  output  1  decoded outputs valid.
- out_ready  input  1  execute stage consumes.
- instrset_latched  output  47  one-hot decode vector.
- imm_decoded  output  32  immediate.
- rs1_decoded  output  32  rs1 operand value.
- rs2_decoded  output  32  rs2 operand value.
- rd_decoded  output  5  destination register.
- pc_decoded  output  32  PC of held instruction.
- illegal_instr  output  1  held instruction matched no encoding.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, instrset_latched=0, imm/rs1/rs2=0, rd=0, pc_decoded=RESET_PC, illegal_instr=0.
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Capture occurs when in_valid && in_ready && !flush.
  - All output registers load the decode of instr_in; out_valid=1 next cycle.
  - Latency: 1 cycle, instruction in to out_valid.
- If out_valid && out_ready and no capture: out_valid=0; data registers hold their last values.
- Otherwise all outputs hold.
- flush has priority: out_valid=0 next cycle and no capture that cycle, regardless of in_valid/out_ready.
- Reset mid-operation: immediate return to reset values; the pending instruction is lost.
- instrset_latched bit map:
  - Bits 46..37: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu.
  - Bits 36..29: lb, lh, lw, lbu, lhu, sb, sh, sw.
  - Bits 28..20: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - Bits 19..10: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - Bits 9..6: fence, fencei, ecall, ebreak.
  - Bits 5..0: csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci.
  - Full opcode/funct3/funct7 match per RV32I.
  - Shifts and R-type require funct7 = 0000000, or 0100000 for sub/sra/srai.
  - ecall is exactly 32'h00000073; ebreak is exactly 32'h00100073.
  - fence: opcode 0001111, funct3 000. fencei: opcode 0001111, funct3 001.
  - No match: vector all zero, illegal_instr=1, out_valid still asserted.
- imm_decoded:
  - I-type/loads/jalr: sext(inst[31:20]).
  - S-type: sext({inst[31:25], inst[11:7]}).
  - B-type: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type: {inst[31:12], 12'b0}.
  - J-type: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Shift-immediates: {27'b0, inst[24:20]}.
  - CSR ops: {20'b0, inst[31:20]}.
  - All others: 0.
- Operand selection, per source:
  - Index 0 gives 0.
  - Else if wb_en && wb_rd==index, gives wb_data (bypass).
  - Else gives rf_rdata.
  - csrr*i: rs1_decoded = {27'b0, inst[19:15]}.
- rd_decoded = inst[11:7] for instructions that write a register.
  - Forced to 0 for branches, stores, fence, fencei, ecall, ebreak, and illegal.

Test Plan:
- Reset, then in_valid=1, instr_in=32'h00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, bit28 only set, imm=5, rs1=0, rd=1, illegal=0.
- instr_in=32'h12345137 (lui x2) -> bit46 set, imm=32'h12345000, rd=2.
- instr_in=32'hFE208EE3 (beq x1,x2,-4), rf_rdata1=7, rf_rdata2=9, wb_en=1, wb_rd=2, wb_data=32'hAA -> bit42 set, imm=32'hFFFFFFFC, rs1=7, rs2=32'hAA, rd=0.
- out_ready=0 with out_valid=1, new in_valid -> in_ready=0; outputs stable for 3 cycles. Then out_ready=1 -> next instruction captured the same cycle, out_valid stays 1.
- flush=1 in the same cycle as in_valid=1 and out_valid=1 -> next cycle out_valid=0, outputs not reloaded.
- instr_in=32'hFFFFFFFF -> out_valid=1, instrset_latched=0, illegal_instr=1, rd=0. Assert rst_n=0 mid-hold -> out_valid=0 without waiting for a clock edge.
